// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host-to-device transmit path.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQUEST,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_RESPOND
    } tx_state_t;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_STOP_INDEX = 9;

    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/clock_synchronizer.sv
// Two-flop synchronizer for a raw pin level; resets to the idle (released) level.
module clock_synchronizer #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset_low,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device frame sender: inhibit, request-to-send, shift on device clock, collect ack.
// Define PS2_TX_RESEND_EN to retry a NAKed or timed-out frame up to MAX_RETRIES times.
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 7500,
    parameter int REQUEST_CYCLES = 150,
    parameter int TIMEOUT_CYCLES = 1200000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic       clk,
    input  logic       reset_low,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_out,
    output logic       ps2_clk_oe,
    input  logic       ps2_data_in,
    output logic       ps2_data_out,
    output logic       ps2_data_oe,
    output logic       command_ready,
    input  logic       command_valid,
    input  logic [7:0] command_byte,
    input  logic       command_ack_ready,
    output logic       command_ack_valid,
    output logic       command_ack_error,
    output tx_state_t  dbg_state
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
                             ((TIMEOUT_CYCLES > REQUEST_CYCLES) ? TIMEOUT_CYCLES : REQUEST_CYCLES) :
                             ((INHIBIT_CYCLES > REQUEST_CYCLES) ? INHIBIT_CYCLES : REQUEST_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
`ifdef PS2_TX_RESEND_EN
    localparam int RETRY_LIMIT = MAX_RETRIES;
`else
    localparam int RETRY_LIMIT = 0;
`endif

    tx_state_t          state_q, state_d;
    logic [7:0]         byte_q, byte_d;
    logic               parity_q, parity_d;
    logic [3:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               nak_q, nak_d;
    logic               clk_oe_q, clk_oe_d;
    logic               data_oe_q, data_oe_d;
    logic               ready_q, ready_d;
    logic               ack_valid_q, ack_valid_d;
    logic               ack_error_q, ack_error_d;
    logic               clk_prev_q;

    logic clk_sync;
    logic data_sync;
    logic clk_fall;
    logic timed_out;
    logic fail;

    clock_synchronizer u_clk_sync (
        .clk       (clk),
        .reset_low (reset_low),
        .async_in  (ps2_clk_in),
        .sync_out  (clk_sync)
    );

    clock_synchronizer u_data_sync (
        .clk       (clk),
        .reset_low (reset_low),
        .async_in  (ps2_data_in),
        .sync_out  (data_sync)
    );

    assign clk_fall  = clk_prev_q & ~clk_sync;
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        parity_d    = parity_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        nak_d       = nak_q;
        data_oe_d   = data_oe_q;
        ack_error_d = ack_error_q;
        fail        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                retry_d = '0;
                if (command_valid && ready_q) begin
                    byte_d      = command_byte;
                    parity_d    = odd_parity(command_byte);
                    idx_d       = '0;
                    cnt_d       = '0;
                    nak_d       = 1'b0;
                    data_oe_d   = 1'b0;
                    ack_error_d = 1'b0;
                    state_d     = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = ST_REQUEST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REQUEST: begin
                if (cnt_q == CNT_W'(REQUEST_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (clk_fall) begin
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    if (idx_q < 4'(PS2_DATA_BITS)) begin
                        data_oe_d = ~byte_q[idx_q[2:0]];
                    end else if (idx_q == 4'(PS2_DATA_BITS)) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                    end
                    if (idx_q == 4'(PS2_STOP_INDEX)) begin
                        state_d = ST_ACK;
                    end
                end else if (timed_out) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    cnt_d   = '0;
                    nak_d   = data_sync;
                    state_d = ST_WAIT_IDLE;
                end else if (timed_out) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    if (nak_q) begin
                        fail = 1'b1;
                    end else begin
                        state_d = ST_RESPOND;
                    end
                end else if (clk_fall) begin
                    cnt_d = '0;
                end else if (timed_out) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESPOND: begin
                if (ack_valid_q && command_ack_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A failed attempt either restarts the same byte or reports the error.
        if (fail) begin
            data_oe_d = 1'b0;
            cnt_d     = '0;
            idx_d     = '0;
            nak_d     = 1'b0;
            if (int'(retry_q) < RETRY_LIMIT) begin
                retry_d = retry_q + 1'b1;
                state_d = ST_INHIBIT;
            end else begin
                ack_error_d = 1'b1;
                state_d     = ST_RESPOND;
            end
        end

        clk_oe_d    = (state_d == ST_INHIBIT) || (state_d == ST_REQUEST);
        ready_d     = (state_d == ST_IDLE);
        ack_valid_d = (state_d == ST_RESPOND);
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state_q     <= ST_IDLE;
            byte_q      <= '0;
            parity_q    <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            retry_q     <= '0;
            nak_q       <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            ready_q     <= 1'b0;
            ack_valid_q <= 1'b0;
            ack_error_q <= 1'b0;
            clk_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            parity_q    <= parity_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            nak_q       <= nak_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            ready_q     <= ready_d;
            ack_valid_q <= ack_valid_d;
            ack_error_q <= ack_error_d;
            clk_prev_q  <= clk_sync;
        end
    end

    assign ps2_clk_out       = 1'b0;
    assign ps2_data_out      = 1'b0;
    assign ps2_clk_oe        = clk_oe_q;
    assign ps2_data_oe       = data_oe_q;
    assign command_ready     = ready_q;
    assign command_ack_valid = ack_valid_q;
    assign command_ack_error = ack_error_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with a simple open-drain PS/2 device model.
module tb_ps2_transmitter;
    import ps2_pkg::*;

    localparam int INH = 20;
    localparam int REQ = 10;
    localparam int TMO = 400;

    logic      clk = 1'b0;
    logic      reset_low = 1'b0;
    logic      dev_clk = 1'b1;
    logic      dev_data = 1'b1;
    logic      ps2_clk_in, ps2_data_in;
    logic      ps2_clk_out, ps2_clk_oe, ps2_data_out, ps2_data_oe;
    logic      command_ready, command_valid = 1'b0;
    logic [7:0] command_byte = 8'h00;
    logic      command_ack_ready = 1'b0;
    logic      command_ack_valid, command_ack_error;
    tx_state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Wired-AND open-drain lines with pull-ups.
    assign ps2_clk_in  = dev_clk & ~(ps2_clk_oe & ~ps2_clk_out);
    assign ps2_data_in = dev_data & ~(ps2_data_oe & ~ps2_data_out);

    always #5 clk = ~clk;

    ps2_transmitter #(
        .INHIBIT_CYCLES (INH),
        .REQUEST_CYCLES (REQ),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES    (2)
    ) dut (
        .clk               (clk),
        .reset_low         (reset_low),
        .ps2_clk_in        (ps2_clk_in),
        .ps2_clk_out       (ps2_clk_out),
        .ps2_clk_oe        (ps2_clk_oe),
        .ps2_data_in       (ps2_data_in),
        .ps2_data_out      (ps2_data_out),
        .ps2_data_oe       (ps2_data_oe),
        .command_ready     (command_ready),
        .command_valid     (command_valid),
        .command_byte      (command_byte),
        .command_ack_ready (command_ack_ready),
        .command_ack_valid (command_ack_valid),
        .command_ack_error (command_ack_error),
        .dbg_state         (dbg_state)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish, expected finish before 5ms");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        check("ready_before_send", command_ready, 1'b1);
        command_byte  = b;
        command_valid = 1'b1;
        tick(1);
        command_valid = 1'b0;
    endtask

    // Measures the inhibit-only and both-low phases up to clock release.
    task automatic do_phases(output int inh, output int req);
        int n;
        n = 0;
        while (!ps2_clk_oe && n < TMO + 200) begin
            tick(1);
            n++;
        end
        check("inhibit_started", ps2_clk_oe, 1'b1);
        inh = 0;
        while (ps2_clk_oe && !ps2_data_oe && inh < 1000) begin
            inh++;
            tick(1);
        end
        req = 0;
        while (ps2_clk_oe && ps2_data_oe && req < 1000) begin
            req++;
            tick(1);
        end
    endtask

    // Device clocks nfalls edges; the 11th edge is the ack slot.
    task automatic dev_frame(input logic ack_bit, input int nfalls, output logic [9:0] bits);
        bits = '0;
        tick(3);
        for (int k = 0; k < nfalls && k < 10; k++) begin
            dev_clk = 1'b0;
            tick(10);
            dev_clk = 1'b1;
            tick(8);
            bits[k] = ps2_data_in;
            tick(2);
        end
        if (nfalls > 10) begin
            dev_data = ack_bit;
            tick(2);
            dev_clk = 1'b0;
            tick(10);
            dev_clk = 1'b1;
            tick(5);
            dev_data = 1'b1;
        end
    endtask

    task automatic wait_ack(input int bound);
        int n;
        n = 0;
        while (!command_ack_valid && n < bound) begin
            tick(1);
            n++;
        end
        check("ack_valid_seen", command_ack_valid, 1'b1);
    endtask

    task automatic consume_ack();
        command_ack_ready = 1'b1;
        tick(1);
        command_ack_ready = 1'b0;
        check("ack_valid_cleared", command_ack_valid, 1'b0);
        check("ready_after_ack", command_ready, 1'b1);
    endtask

    initial begin
        int inh, req;
        logic [9:0] bits;
        logic stable;

        // Reset
        tick(2);
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_data_oe", ps2_data_oe, 1'b0);
        check("rst_ready", command_ready, 1'b0);
        check("rst_ack_valid", command_ack_valid, 1'b0);
        check("rst_ack_error", command_ack_error, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);
        reset_low = 1'b1;
        #1;
        check("ready_before_first_edge", command_ready, 1'b0);
        tick(1);
        check("ready_after_first_edge", command_ready, 1'b1);
        tick(2);

        // 0xED with ack: parity 1
        send_cmd(8'hED);
        do_phases(inh, req);
        check("ed_inhibit_len", inh, INH);
        check("ed_request_len", req, REQ);
        dev_frame(1'b0, 11, bits);
        check("ed_frame_bits", bits, 10'h3ED);
        wait_ack(100);
        check("ed_ack_error", command_ack_error, 1'b0);
        check("ed_clk_released", ps2_clk_oe, 1'b0);
        check("ed_data_released", ps2_data_oe, 1'b0);
        check("ed_ready_while_pending", command_ready, 1'b0);
        consume_ack();

        // 0xF4 with ack: parity 0, phase lengths
        send_cmd(8'hF4);
        do_phases(inh, req);
        check("f4_inhibit_len", inh, INH);
        check("f4_request_len", req, REQ);
        check("f4_clk_released", ps2_clk_oe, 1'b0);
        check("f4_start_bit_held", ps2_data_oe, 1'b1);
        dev_frame(1'b0, 11, bits);
        check("f4_frame_bits", bits, 10'h2F4);
        wait_ack(100);
        check("f4_ack_error", command_ack_error, 1'b0);
        consume_ack();

        // 0xFF, device NAKs
        send_cmd(8'hFF);
`ifdef PS2_TX_RESEND_EN
        for (int a = 0; a < 3; a++) begin
            do_phases(inh, req);
            dev_frame(1'b1, 11, bits);
            check("ff_frame_bits", bits, 10'h3FF);
        end
        wait_ack(100);
        check("ff_nak_error", command_ack_error, 1'b1);
        consume_ack();
        send_cmd(8'hFF);
        do_phases(inh, req);
        dev_frame(1'b1, 11, bits);
        do_phases(inh, req);
        dev_frame(1'b0, 11, bits);
        wait_ack(100);
        check("ff_retry_ok_error", command_ack_error, 1'b0);
        consume_ack();
`else
        do_phases(inh, req);
        dev_frame(1'b1, 11, bits);
        check("ff_frame_bits", bits, 10'h3FF);
        wait_ack(100);
        check("ff_nak_error", command_ack_error, 1'b1);
        consume_ack();
`endif

        // Device stops clocking after bit 4
        send_cmd(8'h55);
`ifdef PS2_TX_RESEND_EN
        for (int a = 0; a < 3; a++) begin
            do_phases(inh, req);
            dev_frame(1'b0, 5, bits);
        end
`else
        do_phases(inh, req);
        dev_frame(1'b0, 5, bits);
`endif
        check("to_no_early_ack", command_ack_valid, 1'b0);
        wait_ack(TMO + 100);
        check("to_error", command_ack_error, 1'b1);
        check("to_clk_released", ps2_clk_oe, 1'b0);
        check("to_data_released", ps2_data_oe, 1'b0);
        consume_ack();

        // Ack held off for 50 cycles while a second command is offered
        send_cmd(8'hF4);
        do_phases(inh, req);
        dev_frame(1'b0, 11, bits);
        wait_ack(100);
        command_byte  = 8'hAA;
        command_valid = 1'b1;
        stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick(1);
            if (!command_ack_valid || command_ack_error || command_ready || ps2_clk_oe)
                stable = 1'b0;
        end
        check("hold_stable", stable, 1'b1);
        consume_ack();
        tick(1);
        command_valid = 1'b0;
        check("queued_cmd_accepted", ps2_clk_oe, 1'b1);

        // Reset in the middle of SEND
        do_phases(inh, req);
        dev_frame(1'b0, 4, bits);
        check("mid_send_data_bits", bits[3:0], 4'hA);
        reset_low = 1'b0;
        #2;
        check("async_rst_clk_oe", ps2_clk_oe, 1'b0);
        check("async_rst_data_oe", ps2_data_oe, 1'b0);
        check("async_rst_ack_valid", command_ack_valid, 1'b0);
        tick(2);
        reset_low = 1'b1;
        tick(3);
        send_cmd(8'hF4);
        do_phases(inh, req);
        check("post_rst_inhibit_len", inh, INH);
        dev_frame(1'b0, 11, bits);
        check("post_rst_frame_bits", bits, 10'h2F4);
        wait_ack(100);
        check("post_rst_ack_error", command_ack_error, 1'b0);
        consume_ack();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
